ex_mem_pipe_reg: RTL

//  EX->MEM pipeline stage register with 2-entry skid buffer (main + skid).

---
 rtl/ex_mem_pipe_reg_if.sv | 43 ++++
 rtl/ex_mem_pipe_reg.sv | 114 +++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg_if.sv
// rtl/ex_mem_pipe_reg_if.sv - EX->MEM beat bundle: EX-side handshake/payload in, MEM-side handshake/payload out
interface ex_mem_pipe_reg_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            EX_valid;
    logic            EX_ready;
    logic [XLEN-1:0] EX_pc;
    logic [XLEN-1:0] EX_aluResult;
    logic [XLEN-1:0] EX_rs2Data;
    logic [RD_W-1:0] EX_rd;
    logic [2:0]      EX_funct3;
    logic            EX_regWrite;
    logic            EX_memRead;
    logic            EX_memWrite;
    logic            EX_memToReg;

    logic            MEM_valid;
    logic            MEM_ready;
    logic [XLEN-1:0] MEM_pc;
    logic [XLEN-1:0] MEM_aluResult;
    logic [XLEN-1:0] MEM_rs2Data;
    logic [RD_W-1:0] MEM_rd;
    logic [2:0]      MEM_funct3;
    logic            MEM_regWrite;
    logic            MEM_memRead;
    logic            MEM_memWrite;
    logic            MEM_memToReg;

    modport slave (
        input  EX_valid, EX_pc, EX_aluResult, EX_rs2Data, EX_rd, EX_funct3,
               EX_regWrite, EX_memRead, EX_memWrite, EX_memToReg, MEM_ready,
        output EX_ready, MEM_valid, MEM_pc, MEM_aluResult, MEM_rs2Data, MEM_rd,
               MEM_funct3, MEM_regWrite, MEM_memRead, MEM_memWrite, MEM_memToReg
    );

    modport master (
        output EX_valid, EX_pc, EX_aluResult, EX_rs2Data, EX_rd, EX_funct3,
               EX_regWrite, EX_memRead, EX_memWrite, EX_memToReg, MEM_ready,
        input  EX_ready, MEM_valid, MEM_pc, MEM_aluResult, MEM_rs2Data, MEM_rd,
               MEM_funct3, MEM_regWrite, MEM_memRead, MEM_memWrite, MEM_memToReg
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX->MEM stage register, main + skid entry; EX_MEM_PERF_EN adds stall/bubble counters
module ex_mem_pipe_reg #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    ex_mem_pipe_reg_if.slave      bus
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_bubble_cnt
`endif
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
        logic [RD_W-1:0] rd;
        logic [2:0]      funct3;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } beat_t;

    logic  r_main_valid;
    logic  r_skid_valid;
    beat_t r_main;
    beat_t r_skid;
    beat_t w_in;
    logic  w_accept;
    logic  w_out;
    logic  w_main_load;

    // Ready comes from registered state only so MEM_ready never reaches EX combinationally.
    assign bus.EX_ready = !r_skid_valid;
    assign w_accept     = bus.EX_valid && !r_skid_valid;
    assign w_out        = r_main_valid && bus.MEM_ready;
    assign w_main_load  = !r_main_valid || w_out;

    always_comb begin
        w_in            = '0;
        w_in.pc         = bus.EX_pc;
        w_in.alu        = bus.EX_aluResult;
        w_in.rs2        = bus.EX_rs2Data;
        w_in.rd         = bus.EX_rd;
        w_in.funct3     = bus.EX_funct3;
        // A write to x0 is dropped here so forwarding never matches it.
        w_in.reg_write  = bus.EX_regWrite && (bus.EX_rd != '0);
        w_in.mem_read   = bus.EX_memRead;
        w_in.mem_write  = bus.EX_memWrite;
        w_in.mem_to_reg = bus.EX_memToReg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_load) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_in;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.MEM_valid     = r_main_valid;
    assign bus.MEM_pc        = r_main.pc;
    assign bus.MEM_aluResult = r_main.alu;
    assign bus.MEM_rs2Data   = r_main.rs2;
    assign bus.MEM_funct3    = r_main.funct3;
    assign bus.MEM_rd        = r_main_valid ? r_main.rd : '0;
    assign bus.MEM_regWrite  = r_main.reg_write  && r_main_valid;
    assign bus.MEM_memRead   = r_main.mem_read   && r_main_valid;
    assign bus.MEM_memWrite  = r_main.mem_write  && r_main_valid;
    assign bus.MEM_memToReg  = r_main.mem_to_reg && r_main_valid;

`ifdef EX_MEM_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Both counters saturate and ignore flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_main_valid && !bus.MEM_ready && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!r_main_valid && (r_bubble_cnt != 32'hFFFF_FFFF))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
`endif
endmodule
